// File: rtl/intc.sv
// rtl/intc.sv - interrupt controller: synchronized irq lines, pending/mask, count/compare timer on line 5
// Optional INTC_PRIO_EN adds a read-only priority encoder register at word 6.
module intc #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [4:0] RESET_EDGE  = 5'b00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  irq_src,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [2:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic        bus_ack,
    output logic [31:0] bus_rdata,
    output logic [5:0]  hard_int
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } bus_state_t;

    bus_state_t state, state_next;

    logic [4:0]  sync_q [SYNC_STAGES];
    logic [4:0]  sync_lvl;
    logic [4:0]  edge_hist;
    logic [4:0]  rise;

    logic [5:0]  pending, pending_next;
    logic [5:0]  mask;
    logic [4:0]  edge_mode;
    logic [31:0] tcount, tcount_next;
    logic [31:0] tcmp;
    logic [1:0]  tctrl;
    logic [5:0]  w1c;
    logic        match;

    logic        access, wr, rd;
    logic [31:0] rd_val;

    assign access = (state == S_IDLE) && bus_req;
    assign wr     = access && bus_we;
    assign rd     = access && !bus_we;

    assign sync_lvl = sync_q[SYNC_STAGES-1];
    assign rise     = sync_lvl & ~edge_hist;
    assign match    = tctrl[0] && (tcount == tcmp);
    assign w1c      = (wr && bus_addr == 3'd0) ? bus_wdata[5:0] : 6'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            edge_hist <= '0;
        end else begin
            sync_q[0] <= irq_src;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            edge_hist <= sync_lvl;
        end
    end

    // A new edge or timer match wins over a same-cycle W1C; a TCMP write beats a match.
    always_comb begin
        pending_next = pending;
        for (int i = 0; i < 5; i++) begin
            if (edge_mode[i]) pending_next[i] = (pending[i] & ~w1c[i]) | rise[i];
            else              pending_next[i] = sync_lvl[i];
        end
        if (wr && bus_addr == 3'd4) pending_next[5] = 1'b0;
        else if (match)             pending_next[5] = 1'b1;
        else                        pending_next[5] = pending[5] & ~w1c[5];
    end

    always_comb begin
        tcount_next = tcount;
        if (wr && bus_addr == 3'd3) tcount_next = bus_wdata;
        else if (tctrl[0])          tcount_next = (match && tctrl[1]) ? 32'd0 : tcount + 32'd1;
    end

`ifdef INTC_PRIO_EN
    logic [5:0]  prio_vec;
    logic [31:0] prio;
    assign prio_vec = pending & mask;

    // Scan downward so the lowest set index is the one left standing.
    always_comb begin
        prio = 32'd0;
        for (int i = 5; i >= 0; i--) begin
            if (prio_vec[i]) prio = {1'b1, 28'd0, 3'(i)};
        end
    end
`endif

    always_comb begin
        rd_val = 32'd0;
        case (bus_addr)
            3'd0: rd_val = {26'd0, pending};
            3'd1: rd_val = {26'd0, mask};
            3'd2: rd_val = {27'd0, edge_mode};
            3'd3: rd_val = tcount;
            3'd4: rd_val = tcmp;
            3'd5: rd_val = {30'd0, tctrl};
`ifdef INTC_PRIO_EN
            3'd6: rd_val = prio;
`endif
            default: rd_val = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            mask      <= '0;
            edge_mode <= RESET_EDGE;
            tcount    <= '0;
            tcmp      <= 32'hFFFF_FFFF;
            tctrl     <= '0;
            hard_int  <= '0;
            bus_rdata <= '0;
        end else begin
            pending   <= pending_next;
            tcount    <= tcount_next;
            hard_int  <= pending & mask;
            bus_rdata <= rd ? rd_val : 32'd0;
            if (wr) begin
                case (bus_addr)
                    3'd1:    mask      <= bus_wdata[5:0];
                    3'd2:    edge_mode <= bus_wdata[4:0];
                    3'd4:    tcmp      <= bus_wdata;
                    3'd5:    tctrl     <= bus_wdata[1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // WAIT holds off a still-asserted request so it is not serviced twice.
    always_comb begin
        state_next = state;
        bus_ack    = 1'b0;
        case (state)
            S_IDLE: if (bus_req) state_next = S_ACK;
            S_ACK: begin
                bus_ack    = 1'b1;
                state_next = S_WAIT;
            end
            S_WAIT: if (!bus_req) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

endmodule
